// File: rtl/dual_commit_regfile.sv
// dual_commit_regfile: 32x32 GPR file with two commit write slots (slot 2 wins collisions) and four bypassed combinational read ports.
// Defining COMMIT_TRACE_EN adds a registered commit-trace port; otherwise all trace outputs are tied to 0.
`ifndef WS_TO_RF_BUS_WD
`define WS_TO_RF_BUS_WD 140
`endif
module dual_commit_regfile (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [`WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  input  logic [4:0]                  raddr1a,
  input  logic [4:0]                  raddr1b,
  input  logic [4:0]                  raddr2a,
  input  logic [4:0]                  raddr2b,
  output logic [31:0]                 rdata1a,
  output logic [31:0]                 rdata1b,
  output logic [31:0]                 rdata2a,
  output logic [31:0]                 rdata2b,
  output logic [31:0]                 debug_wb_pc1,
  output logic [31:0]                 debug_wb_pc2,
  output logic [3:0]                  debug_wb_rf_we1,
  output logic [3:0]                  debug_wb_rf_we2,
  output logic [4:0]                  debug_wb_rf_wnum1,
  output logic [4:0]                  debug_wb_rf_wnum2,
  output logic [31:0]                 debug_wb_rf_wdata1,
  output logic [31:0]                 debug_wb_rf_wdata2,
  output logic [31:0]                 commit_wr_cnt
);
  logic [31:0] pc1, pc2, wdata1, wdata2;
  logic        we1, we2, wen1, wen2;
  logic [4:0]  waddr1, waddr2;
  logic [31:0] rf [1:31];
  logic [4:0]  ra [4];
  logic [31:0] rd [4];
  assign {pc1, we1, waddr1, wdata1, pc2, we2, waddr2, wdata2} = ws_to_rf_bus;
  // slot 2 is younger, so it masks slot 1 on a same-register collision
  assign wen1 = we1 && waddr1 != 5'd0 && !(we2 && waddr2 == waddr1);
  assign wen2 = we2 && waddr2 != 5'd0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 1; i < 32; i++) rf[i] <= '0;
    else begin
      if (wen1) rf[waddr1] <= wdata1;
      if (wen2) rf[waddr2] <= wdata2;
    end
  assign ra = '{raddr1a, raddr1b, raddr2a, raddr2b};
  for (genvar p = 0; p < 4; p++) begin : g_rd
    assign rd[p] = ra[p] == 5'd0                 ? 32'd0  :
                   wen2 && ra[p] == waddr2       ? wdata2 :
                   wen1 && ra[p] == waddr1       ? wdata1 : rf[ra[p]];
  end
  assign {rdata1a, rdata1b, rdata2a, rdata2b} = {rd[0], rd[1], rd[2], rd[3]};
`ifdef COMMIT_TRACE_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      debug_wb_pc1       <= '0;
      debug_wb_pc2       <= '0;
      debug_wb_rf_we1    <= '0;
      debug_wb_rf_we2    <= '0;
      debug_wb_rf_wnum1  <= '0;
      debug_wb_rf_wnum2  <= '0;
      debug_wb_rf_wdata1 <= '0;
      debug_wb_rf_wdata2 <= '0;
      commit_wr_cnt      <= '0;
    end else begin
      debug_wb_pc1       <= pc1;
      debug_wb_pc2       <= pc2;
      debug_wb_rf_we1    <= {4{wen1}};
      debug_wb_rf_we2    <= {4{wen2}};
      debug_wb_rf_wnum1  <= waddr1;
      debug_wb_rf_wnum2  <= waddr2;
      debug_wb_rf_wdata1 <= wdata1;
      debug_wb_rf_wdata2 <= wdata2;
      commit_wr_cnt      <= commit_wr_cnt + 32'(wen1) + 32'(wen2);
    end
`else
  assign debug_wb_pc1       = '0;
  assign debug_wb_pc2       = '0;
  assign debug_wb_rf_we1    = '0;
  assign debug_wb_rf_we2    = '0;
  assign debug_wb_rf_wnum1  = '0;
  assign debug_wb_rf_wnum2  = '0;
  assign debug_wb_rf_wdata1 = '0;
  assign debug_wb_rf_wdata2 = '0;
  assign commit_wr_cnt      = '0;
`endif
endmodule

// File: tb/tb_dual_commit_regfile.sv
// tb_dual_commit_regfile: directed scoreboard bench for dual_commit_regfile.
// Trace expectations collapse to 0 unless COMMIT_TRACE_EN is defined.
module tb_dual_commit_regfile;
  logic        clk = 0;
  logic        reset = 0;
  logic [139:0] bus = '0;
  logic [4:0]  raddr1a = 0, raddr1b = 0, raddr2a = 0, raddr2b = 0;
  logic [31:0] rdata1a, rdata1b, rdata2a, rdata2b;
  logic [31:0] debug_wb_pc1, debug_wb_pc2, debug_wb_rf_wdata1, debug_wb_rf_wdata2, commit_wr_cnt;
  logic [3:0]  debug_wb_rf_we1, debug_wb_rf_we2;
  logic [4:0]  debug_wb_rf_wnum1, debug_wb_rf_wnum2;
  int total = 0, bad = 0;
  event chk;
  typedef struct { string nm; int sel; logic [31:0] v; } exp_t;
  exp_t q[$];

  dual_commit_regfile dut (
    .clk(clk), .reset(reset), .ws_to_rf_bus(bus),
    .raddr1a(raddr1a), .raddr1b(raddr1b), .raddr2a(raddr2a), .raddr2b(raddr2b),
    .rdata1a(rdata1a), .rdata1b(rdata1b), .rdata2a(rdata2a), .rdata2b(rdata2b),
    .debug_wb_pc1(debug_wb_pc1), .debug_wb_pc2(debug_wb_pc2),
    .debug_wb_rf_we1(debug_wb_rf_we1), .debug_wb_rf_we2(debug_wb_rf_we2),
    .debug_wb_rf_wnum1(debug_wb_rf_wnum1), .debug_wb_rf_wnum2(debug_wb_rf_wnum2),
    .debug_wb_rf_wdata1(debug_wb_rf_wdata1), .debug_wb_rf_wdata2(debug_wb_rf_wdata2),
    .commit_wr_cnt(commit_wr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      0: return rdata1a;
      1: return rdata1b;
      2: return rdata2a;
      3: return rdata2b;
      4: return debug_wb_pc1;
      5: return debug_wb_pc2;
      6: return 32'(debug_wb_rf_we1);
      7: return 32'(debug_wb_rf_we2);
      8: return 32'(debug_wb_rf_wnum1);
      9: return 32'(debug_wb_rf_wnum2);
      10: return debug_wb_rf_wdata1;
      11: return debug_wb_rf_wdata2;
      default: return commit_wr_cnt;
    endcase
  endfunction

  // monitor: drains pending expectations at each falling edge or on demand
  initial forever begin
    @(negedge clk or chk);
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = sample(e.sel);
      total++;
      if (a !== e.v) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.nm, a, e.v);
      end
    end
  end

  task automatic expect_v(input string nm, input int sel, input logic [31:0] v);
    exp_t e;
`ifndef COMMIT_TRACE_EN
    if (sel >= 4) v = '0;
`endif
    e.nm = nm; e.sel = sel; e.v = v;
    q.push_back(e);
  endtask

  task automatic drive(input logic w1, input logic [4:0] a1, input logic [31:0] d1, input logic [31:0] p1,
                       input logic w2, input logic [4:0] a2, input logic [31:0] d2, input logic [31:0] p2);
    bus = {p1, w1, a1, d1, p2, w2, a2, d2};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    raddr1a = 5; raddr1b = 31; raddr2a = 0; raddr2b = 5;
    expect_v("rst_r5_1a", 0, 0);
    expect_v("rst_r31_1b", 1, 0);
    expect_v("rst_r0_2a", 2, 0);
    expect_v("rst_r5_2b", 3, 0);
    expect_v("rst_cnt", 12, 0);
    step(); step();
    reset = 1;
    // single write to r3 with same-cycle bypass
    drive(1, 3, 32'hDEADBEEF, 32'h1000, 0, 0, 0, 32'h1004);
    raddr1a = 3; raddr1b = 0; raddr2a = 0; raddr2b = 0;
    expect_v("byp_r3", 0, 32'hDEADBEEF);
    expect_v("byp_r0", 1, 0);
    step();
    drive(0, 0, 0, 32'h2000, 0, 0, 0, 32'h2004);
    expect_v("stored_r3", 0, 32'hDEADBEEF);
    expect_v("tr_pc1_a", 4, 32'h1000);
    expect_v("tr_we1_a", 6, 32'hF);
    expect_v("tr_we2_a", 7, 0);
    expect_v("tr_wnum1_a", 8, 3);
    expect_v("tr_wdata1_a", 10, 32'hDEADBEEF);
    expect_v("tr_cnt_a", 12, 1);
    step();
    // collision on r7: slot 2 wins
    drive(1, 7, 32'h1, 32'h3000, 1, 7, 32'h2, 32'h3004);
    raddr2a = 7;
    expect_v("coll_byp", 2, 32'h2);
    expect_v("coll_r3", 0, 32'hDEADBEEF);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_v("coll_stored", 2, 32'h2);
    expect_v("tr_we1_coll", 6, 0);
    expect_v("tr_we2_coll", 7, 32'hF);
    expect_v("tr_wnum2_coll", 9, 7);
    expect_v("tr_wdata1_coll", 10, 32'h1);
    expect_v("tr_wdata2_coll", 11, 32'h2);
    expect_v("tr_cnt_coll", 12, 2);
    step();
    // write to r0 is dropped
    drive(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0);
    raddr1b = 0; raddr2b = 0;
    expect_v("r0w_1b", 1, 0);
    expect_v("r0w_2b", 3, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_v("r0w_after", 1, 0);
    expect_v("tr_we2_r0", 7, 0);
    expect_v("tr_wdata2_r0", 11, 32'hFFFF_FFFF);
    expect_v("tr_cnt_r0", 12, 2);
    step();
    // dual write to distinct registers
    drive(1, 1, 32'hA, 32'h4000, 1, 2, 32'hB, 32'h4004);
    raddr1a = 1; raddr1b = 2; raddr2a = 2; raddr2b = 1;
    expect_v("dual_byp_1a", 0, 32'hA);
    expect_v("dual_byp_1b", 1, 32'hB);
    expect_v("dual_byp_2a", 2, 32'hB);
    expect_v("dual_byp_2b", 3, 32'hA);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_v("dual_r1", 0, 32'hA);
    expect_v("dual_r2", 1, 32'hB);
    expect_v("tr_pc1_dual", 4, 32'h4000);
    expect_v("tr_pc2_dual", 5, 32'h4004);
    expect_v("tr_we1_dual", 6, 32'hF);
    expect_v("tr_we2_dual", 7, 32'hF);
    expect_v("tr_cnt_dual", 12, 4);
    step();
    // write r9 then reset asynchronously between edges
    drive(1, 9, 32'h55, 0, 0, 0, 0, 0);
    raddr2b = 9;
    expect_v("r9_byp", 3, 32'h55);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_v("r9_stored", 3, 32'h55);
    expect_v("r9_cnt", 12, 5);
    @(negedge clk);
    #2;
    reset = 0;
    #1;
    expect_v("arst_r9", 3, 0);
    expect_v("arst_r1", 0, 0);
    expect_v("arst_cnt", 12, 0);
    -> chk;
    step();
    expect_v("arst_hold_r9", 3, 0);
    expect_v("arst_hold_r2", 1, 0);
    step();
    reset = 1;
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dual_commit_regfile.md
# dual_commit_regfile

Dual-write, quad-read general-purpose register file that consumes the writeback stage's two-slot commit bus. It holds the 32×32-bit architectural registers (r0 hardwired zero) and serves four combinational read ports to decode/issue, two per issue slot. Same-cycle writes are bypassed to the read ports. Colliding writes resolve in favour of slot 2, the younger instruction. An optional registered commit-trace port feeds the difftest/trace harness.

## Interface
- No parameters. Bus width comes from `WS_TO_RF_BUS_WD` (140) in `define.vh`.
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset: asserted when 0, released synchronously to `clk` by the system.
- `ws_to_rf_bus`  in  140  Fields, MSB first: {pc1[31:0], we1, waddr1[4:0], wdata1[31:0], pc2[31:0], we2, waddr2[4:0], wdata2[31:0]}. Slot 1 is the older instruction.
- `raddr1a`, `raddr1b`, `raddr2a`, `raddr2b`  in  5 each  Read addresses: slot 1 src a/b and slot 2 src a/b.
- `rdata1a`, `rdata1b`, `rdata2a`, `rdata2b`  out  32 each  Read data, combinational.
- `debug_wb_pc1`, `debug_wb_pc2`  out  32  Trace: committed PC.
- `debug_wb_rf_we1`, `debug_wb_rf_we2`  out  4  Trace: byte-enable, 4'hF when the slot wrote.
- `debug_wb_rf_wnum1`, `debug_wb_rf_wnum2`  out  5  Trace: destination register.
- `debug_wb_rf_wdata1`, `debug_wb_rf_wdata2`  out  32  Trace: written value.
- `commit_wr_cnt`  out  32  Trace: count of architectural register writes performed.

## Operation
- Storage: r1–r31, 32-bit flops. r0 has no storage.
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0.
- Effective write enables:
  - `wen1 = we1 && waddr1!=0 && !(we2 && waddr2==waddr1)`
  - `wen2 = we2 && waddr2!=0`
  - Slot-2 priority is enforced here even though writeback already masks we1 on collision.
- Write: on the clock edge, `rf[waddr1]<=wdata1` if `wen1`, and `rf[waddr2]<=wdata2` if `wen2`.
- Read, per port, with priority in this order:
  - address 0 → 0;
  - `wen2 && raddr==waddr2` → wdata2;
  - `wen1 && raddr==waddr1` → wdata1;
  - otherwise `rf[raddr]`.
- The read path is purely combinational. No read enable; ports are always live.
- pc1/pc2 feed only the trace logic.

## Timing
- Write latency: 1 cycle into the array, 0 cycles to the readers via bypass.
- Reset (`reset`=0): all registers cleared to 0 asynchronously. Read outputs are therefore 0 for every address during and after reset until written.
- Reset mid-operation: a write presented in the same cycle that reset asserts is lost. The array stays 0 until the first edge with `reset`=1.
- Same-address, both-write: slot 2 data lands, and slot 2 data is bypassed.
- Both slots writing r0: no state change. Reads of r0 return 0.
- No stall or handshake: every cycle's bus content is taken as committed. Writeback gates `we` with validity.

## Configuration
- `COMMIT_TRACE_EN` defined:
  - Trace outputs are registered, 1-cycle latency after the commit edge.
  - `debug_wb_rf_we*` = {4{wen*}} using effective enables, so a masked slot-1 collision or an r0 write shows 4'h0. `debug_wb_rf_wnum*`/`debug_wb_rf_wdata*`/`debug_wb_pc*` capture the bus fields every cycle.
  - `commit_wr_cnt` increments by wen1+wen2 (0, 1 or 2) per cycle and wraps at 2^32.
  - All trace registers reset to 0.
- `COMMIT_TRACE_EN` undefined:
  - All `debug_*` outputs and `commit_wr_cnt` are tied to constant 0.
  - No trace flops are instantiated.
  - Array behaviour is identical.

## Test plan
- Reset then read: hold `reset`=0 two cycles; all four ports read r5, r31, r0 → 0. With trace enabled, `commit_wr_cnt`=0.
- Single write + bypass:
  - Cycle 0: we1=1, waddr1=3, wdata1=32'hDEADBEEF, raddr1a=3 → rdata1a=32'hDEADBEEF in the same cycle.
  - Next cycle, bus idle → r3 still reads 32'hDEADBEEF.
- Collision: we1=we2=1, waddr1=waddr2=7, wdata1=32'h1, wdata2=32'h2 → bypass and stored value both 32'h2. Trace shows we1=4'h0, we2=4'hF, and the counter advances by 1.
- r0 write: we2=1, waddr2=0, wdata2=32'hFFFF_FFFF → r0 reads 0, trace we2=4'h0, counter unchanged.
- Dual write, distinct registers: r1←32'hA and r2←32'hB in one cycle → next cycle r1=32'hA, r2=32'hB. Counter +2. Trace pc1/pc2 match the bus one cycle later.
- Async reset mid-stream: drop `reset` between edges after writing r9=32'h55 → r9 reads 0 immediately, without waiting for a clock edge. The counter clears to 0.
